// File: rtl/spmv_pkg.sv
// Shared types and constants for the sparse matrix-vector row scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package spmv_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    // Row field of the tag is sized generously; the scheduler narrows it to ROW_W.
    localparam int TAG_ROW_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_ROW_W-1:0] row;
        logic                 last;
    } tag_t;

endpackage

// File: rtl/spmv_prod_fifo.sv
// Synchronous show-ahead FIFO holding {product, row, last} results.
// Latency: a push is visible on rd_vld/rd_dat the following cycle.
// Backpressure: pop only when rd_rdy and not empty; push on a full FIFO is dropped unless a pop frees the slot.
module spmv_prod_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 33,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop    = rd_rdy && (count_q != '0);
    assign push   = wr_vld && ((count_q != CW'(DEPTH)) || pop);
    assign rd_vld = (count_q != '0);
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign count  = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the FIFO.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spmv_row_sched.sv
// Streams CSR nonzeros to an external fp16 multiplier and queues tagged products per row.
// Latency: element accepted at cycle t gives m_valid at t+2+MUL_LAT at the earliest.
// Backpressure: s_ready is a credit check (FIFO count + in-flight < FIFO_DEPTH); the multiplier never stalls.
module spmv_row_sched
    import spmv_pkg::*;
#(
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_W      = 16,
    parameter int COL_W      = 12
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ROW_W-1:0]  i_nrows,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FP16_W-1:0] s_value,
    input  logic [COL_W-1:0]  s_col,
    input  logic              s_last,
    output logic [COL_W-1:0]  o_vec_addr,
    input  logic [FP16_W-1:0] i_vec_rdata,
    output logic [FP16_W-1:0] o_mul_vector,
    output logic [FP16_W-1:0] o_mul_value,
    input  logic [FP16_W-1:0] i_mul_result,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FP16_W-1:0] m_product,
    output logic [ROW_W-1:0]  m_row,
    output logic              m_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int FW = FP16_W + ROW_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(MUL_LAT + 2);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  nrows_q, nrows_d;
    logic [FP16_W-1:0] value_q, value_d;
    tag_t              tag_q [MUL_LAT+1];
    tag_t              tag_d [MUL_LAT+1];
    logic              done_q, done_d;

    logic              s_acc;
    logic              last_row;
    logic              drain_empty;
    logic              credit_ok;
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_wr_vld;
    logic [FW-1:0]     fifo_wr_dat;
    logic [FW-1:0]     fifo_rd_dat;

    assign s_acc       = s_valid && s_ready;
    assign last_row    = (row_q == (nrows_q - ROW_W'(1)));
    assign drain_empty = (inflight == '0) && !m_valid;
    assign credit_ok   = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);

    // Count issued elements still travelling through the multiplier.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            inflight = inflight + IW'(tag_q[i].valid);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a zero-row pass never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start && (i_nrows != '0)) state_d = ST_RUN;
            ST_RUN:   if (s_acc && s_last && last_row) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: input credit, busy flag and end-of-pass pulse request.
    always_comb begin
        s_ready = 1'b0;
        done_d  = 1'b0;
        o_busy  = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  done_d  = i_start && (i_nrows == '0);
            ST_RUN:   s_ready = credit_ok;
            ST_DRAIN: done_d  = drain_empty;
            default:  ;
        endcase
    end

    // Row bookkeeping, operand capture and the tag pipeline that mirrors the multiplier.
    always_comb begin
        nrows_d = nrows_q;
        row_d   = row_q;
        if ((state_q == ST_IDLE) && i_start) begin
            nrows_d = i_nrows;
            row_d   = '0;
        end else if (s_acc && s_last) begin
            row_d = row_q + ROW_W'(1);
        end

        value_d = s_acc ? s_value : FP16_ZERO;

        tag_d[0] = '0;
        if (s_acc) begin
            tag_d[0].valid = 1'b1;
            tag_d[0].row   = TAG_ROW_W'(row_q);
            tag_d[0].last  = s_last;
        end
        for (int i = 1; i <= MUL_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Datapath registers; reset discards all in-flight tags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            nrows_q <= '0;
            row_q   <= '0;
            value_q <= FP16_ZERO;
            done_q  <= 1'b0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            nrows_q <= nrows_d;
            row_q   <= row_d;
            value_q <= value_d;
            done_q  <= done_d;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // The RAM read is issued straight from the stream; operands are zero unless an issue is live.
    assign o_vec_addr   = s_col;
    assign o_mul_value  = tag_q[0].valid ? value_q : FP16_ZERO;
    assign o_mul_vector = tag_q[0].valid ? i_vec_rdata : FP16_ZERO;
    assign o_done       = done_q;

    // The oldest tag lines up with the multiplier output.
    assign fifo_wr_vld = tag_q[MUL_LAT].valid;
    assign fifo_wr_dat = {i_mul_result, tag_q[MUL_LAT].row[ROW_W-1:0], tag_q[MUL_LAT].last};

    spmv_prod_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_prod_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_count)
    );

    assign {m_product, m_row, m_last} = fifo_rd_dat;

endmodule

// File: tb/tb_spmv_row_sched.sv
// Scoreboard bench for spmv_row_sched with a vector RAM and fp16 multiplier stub.
// Latency: expected products are queued at accept and popped by the output monitor.
// Backpressure: m_ready is held low in one scenario to fill the product FIFO.
module tb_spmv_row_sched;

    localparam int MUL_LAT    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ROW_W      = 16;
    localparam int COL_W      = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start;
    logic [ROW_W-1:0] i_nrows;
    logic             s_valid;
    logic             s_ready;
    logic [15:0]      s_value;
    logic [COL_W-1:0] s_col;
    logic             s_last;
    logic [COL_W-1:0] o_vec_addr;
    logic [15:0]      vec_rdata;
    logic [15:0]      o_mul_vector;
    logic [15:0]      o_mul_value;
    logic [15:0]      mul_result;
    logic             m_valid;
    logic             m_ready;
    logic [15:0]      m_product;
    logic [ROW_W-1:0] m_row;
    logic             m_last;
    logic             o_busy;
    logic             o_done;

    always #5 clk = ~clk;

    spmv_row_sched #(
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_start      (i_start),
        .i_nrows      (i_nrows),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_value      (s_value),
        .s_col        (s_col),
        .s_last       (s_last),
        .o_vec_addr   (o_vec_addr),
        .i_vec_rdata  (vec_rdata),
        .o_mul_vector (o_mul_vector),
        .o_mul_value  (o_mul_value),
        .i_mul_result (mul_result),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_product    (m_product),
        .m_row        (m_row),
        .m_last       (m_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // Vector RAM: col0=1.0 col1=2.0 col2=3.0 col3=4.0 col4=0.5 col5=7.0
    logic [15:0] vec_mem [16];
    always @(posedge clk) vec_rdata <= vec_mem[o_vec_addr[3:0]];

    // fp16 multiply for normal operands with exactly representable products.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma;
        logic [10:0] mb;
        logic [21:0] p;
        int          e;
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return 16'h0000;
        ma = {1'b1, a[9:0]};
        mb = {1'b1, b[9:0]};
        p  = 22'(ma) * 22'(mb);
        e  = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            e = e + 1;
            return {a[15] ^ b[15], e[4:0], p[20:11]};
        end
        return {a[15] ^ b[15], e[4:0], p[19:10]};
    endfunction

    logic [15:0] mp1, mp2, mp3;
    always @(posedge clk) begin
        mp1 <= fp16_mul(o_mul_value, o_mul_vector);
        mp2 <= mp1;
        mp3 <= mp2;
    end
    assign mul_result = mp3;

    typedef struct {
        logic [15:0] prod;
        logic [15:0] row;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    time  t_acc;
    time  t_first;
    bit   first_seen = 1'b0;
    bit   drv_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks stability while stalled.
    logic        hold_vld = 1'b0;
    logic [15:0] hold_prod;
    logic [15:0] hold_row;
    logic        hold_last;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                if (!m_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL m_valid_dropped: got 0 expected 1 at %0t", $time);
                end else begin
                    chk("hold_product", 32'(m_product), 32'(hold_prod));
                    chk("hold_row", 32'(m_row), 32'(hold_row));
                    chk("hold_last", 32'(m_last), 32'(hold_last));
                end
            end
            hold_vld = 1'b0;
            if (m_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    t_first    = $time;
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_product: got %h row %h expected none", m_product, m_row);
                    end else begin
                        e = exp_q.pop_front();
                        chk("product", 32'(m_product), 32'(e.prod));
                        chk("row", 32'(m_row), 32'(e.row));
                        chk("last", 32'(m_last), 32'(e.last));
                    end
                end else begin
                    hold_vld  = 1'b1;
                    hold_prod = m_product;
                    hold_row  = m_row;
                    hold_last = m_last;
                end
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic [COL_W-1:0] c, input logic l,
                        input logic [15:0] ep, input logic [15:0] er, output bit ok);
        logic r;
        ok = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_value = v;
        s_col   = c;
        s_last  = l;
        for (int k = 0; k < 400; k++) begin
            #1;
            r = s_ready;
            @(posedge clk);
            if (r) begin
                ok    = 1'b1;
                t_acc = $time;
                acc_cnt++;
                exp_q.push_back('{prod: ep, row: er, last: l});
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready 0 expected accept of %h", v);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic start_pass(input logic [ROW_W-1:0] n);
        @(negedge clk);
        i_start = 1'b1;
        i_nrows = n;
        @(negedge clk);
        i_start = 1'b0;
        #2;
        chk("busy_after_start", 32'(o_busy), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #2;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_at_done", 32'(o_busy), 32'd0);
            chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // Table for the stalled-output scenario: value 1.0 times vec[col].
    logic [COL_W-1:0] t3_col  [10];
    logic [15:0]      t3_prod [10];

    initial begin
        bit ok;
        int base;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base;
        i_start = 1'b0;
        i_nrows = '0;
        s_valid = 1'b0;
        s_value = 16'h0;
        s_col   = 12'h5A5;
        s_last  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) vec_mem[i] = 16'h3C00;
        vec_mem[0] = 16'h3C00;
        vec_mem[1] = 16'h4000;
        vec_mem[2] = 16'h4200;
        vec_mem[3] = 16'h4400;
        vec_mem[4] = 16'h3800;
        vec_mem[5] = 16'h4700;
        t3_col  = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd0, 12'd1, 12'd2, 12'd3};
        t3_prod = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800,
                    16'h4700, 16'h3C00, 16'h4000, 16'h4200, 16'h4400};

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_product", 32'(m_product), 32'd0);
        chk("rst_m_row", 32'(m_row), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_mul_vector", 32'(o_mul_vector), 32'd0);
        chk("rst_mul_value", 32'(o_mul_value), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_vec_addr", 32'(o_vec_addr), 32'h5A5);
        @(negedge clk);
        rst_n = 1'b1;

        // Single element: 3.0 * 7.0 = 21.0
        start_pass(16'd1);
        chk("idle_mul_vector", 32'(o_mul_vector), 32'd0);
        send(16'h4200, 12'd5, 1'b1, 16'h4D40, 16'd0, ok);
        #2;
        chk("issue_mul_value", 32'(o_mul_value), 32'h4200);
        chk("issue_mul_vector", 32'(o_mul_vector), 32'h4700);
        drop_valid();
        wait_done("t1_done");
        chk("t1_latency", 32'((t_first - t_acc + 3) / 10), 32'd5);

        // Three rows of 2,1,3 elements with an ignored start mid-pass
        start_pass(16'd3);
        send(16'h4000, 12'd0, 1'b0, 16'h4000, 16'd0, ok);
        send(16'h4200, 12'd1, 1'b1, 16'h4600, 16'd0, ok);
        send(16'h4400, 12'd2, 1'b1, 16'h4A00, 16'd1, ok);
        @(negedge clk);
        s_valid = 1'b0;
        i_start = 1'b1;
        i_nrows = 16'd7;
        @(negedge clk);
        i_start = 1'b0;
        #2;
        chk("busy_after_ignored_start", 32'(o_busy), 32'd1);
        send(16'h3C00, 12'd3, 1'b0, 16'h4400, 16'd2, ok);
        send(16'h4000, 12'd4, 1'b0, 16'h3C00, 16'd2, ok);
        send(16'h4500, 12'd5, 1'b1, 16'h5060, 16'd2, ok);
        drop_valid();
        wait_done("t2_done");

        // Output stalled: exactly FIFO_DEPTH elements accepted
        @(negedge clk);
        m_ready  = 1'b0;
        drv_done = 1'b0;
        base     = acc_cnt;
        start_pass(16'd1);
        fork
            begin
                bit fok;
                for (int i = 0; i < 10; i++) begin
                    send(16'h3C00, t3_col[i], (i == 9), t3_prod[i], 16'd0, fok);
                end
                drop_valid();
                drv_done = 1'b1;
            end
        join_none
        repeat (30) @(negedge clk);
        #2;
        chk("stall_accept_count", 32'(acc_cnt - base), 32'd8);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        chk("stall_m_valid", 32'(m_valid), 32'd1);
        @(negedge clk);
        m_ready = 1'b1;
        for (int k = 0; k < 300 && !drv_done; k++) @(negedge clk);
        chk("stall_driver_done", 32'(drv_done), 32'd1);
        wait_done("t3_done");

        // Zero-row pass
        @(negedge clk);
        i_start = 1'b1;
        i_nrows = 16'd0;
        @(negedge clk);
        i_start = 1'b0;
        #2;
        chk("zero_done", 32'(o_done), 32'd1);
        chk("zero_busy", 32'(o_busy), 32'd0);
        chk("zero_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("zero_done_pulse", 32'(o_done), 32'd0);
        chk("zero_busy_after", 32'(o_busy), 32'd0);

        // Reset during DRAIN with three products in flight
        start_pass(16'd1);
        send(16'h4000, 12'd0, 1'b0, 16'h4000, 16'd0, ok);
        send(16'h4200, 12'd1, 1'b0, 16'h4600, 16'd0, ok);
        send(16'h4400, 12'd2, 1'b1, 16'h4A00, 16'd0, ok);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        chk("drain_busy", 32'(o_busy), 32'd1);
        chk("drain_s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("post_rst_no_stale", 32'(m_valid), 32'd0);
        start_pass(16'd1);
        send(16'h4000, 12'd2, 1'b1, 16'h4600, 16'd0, ok);
        drop_valid();
        wait_done("t5_done");

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
